ysyx_24070014_mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the NPC memory port. Masters are IFU (m0) and LSU (m1).
- Uses round-robin grant and holds the grant for one complete request+response transaction.
- Drives the select of the request/response steering muxes, and sits between the IFU/LSU and the single SRAM/bus bridge.

---
 rtl/ysyx_24070014_arb_pkg.sv | 13 +
 rtl/ysyx_24070014_rr_pick2.sv | 12 +
 rtl/ysyx_24070014_mem_arbiter.sv | 118 +++++++++++
 tb/tb_ysyx_24070014_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070014_arb_pkg.sv
// Shared encodings for the NPC memory-port arbiter: FSM states and master indices.
package ysyx_24070014_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24070014_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module ysyx_24070014_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       any
);

  assign any  = |req;
  assign pick = (&req) ? ~last : req[1];

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// IFU/LSU to single-slave memory arbiter; grant is held for one full request+response.
module ysyx_24070014_mem_arbiter
  import ysyx_24070014_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic                m0_req_wen,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  input  logic [DATA_W/8-1:0] m0_req_wmask,
  output logic                m0_resp_valid,
  input  logic                m0_resp_ready,
  output logic [DATA_W-1:0]   m0_resp_rdata,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic                m1_req_wen,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  input  logic [DATA_W/8-1:0] m1_req_wmask,
  output logic                m1_resp_valid,
  input  logic                m1_resp_ready,
  output logic [DATA_W-1:0]   m1_resp_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_req_addr,
  output logic                s_req_wen,
  output logic [DATA_W-1:0]   s_req_wdata,
  output logic [DATA_W/8-1:0] s_req_wmask,
  input  logic                s_resp_valid,
  input  logic [DATA_W-1:0]   s_resp_rdata,
  output logic                s_resp_ready,
  output logic                gnt,
  output logic                busy
);

  arb_state_e state, state_next;
  logic       gnt_q, gnt_next;
  logic       last_q, last_next;
  logic       pick, any;

  ysyx_24070014_rr_pick2 u_pick (
    .req  ({m1_req_valid, m0_req_valid}),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  // last resets to LSU so the IFU wins the first tie after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ARB_IDLE;
      gnt_q  <= MST_IFU;
      last_q <= MST_LSU;
    end else begin
      state  <= state_next;
      gnt_q  <= gnt_next;
      last_q <= last_next;
    end
  end

  always_comb begin
    state_next    = state;
    gnt_next      = gnt_q;
    last_next     = last_q;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;
    m0_resp_rdata = '0;
    m1_resp_rdata = '0;
    s_req_valid   = 1'b0;
    s_req_addr    = '0;
    s_req_wen     = 1'b0;
    s_req_wdata   = '0;
    s_req_wmask   = '0;
    s_resp_ready  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          gnt_next   = pick;
          state_next = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // a dropped valid here is a master protocol error; we simply keep waiting
        s_req_valid = (gnt_q == MST_LSU) ? m1_req_valid : m0_req_valid;
        s_req_addr  = (gnt_q == MST_LSU) ? m1_req_addr  : m0_req_addr;
        s_req_wen   = (gnt_q == MST_LSU) ? m1_req_wen   : m0_req_wen;
        s_req_wdata = (gnt_q == MST_LSU) ? m1_req_wdata : m0_req_wdata;
        s_req_wmask = (gnt_q == MST_LSU) ? m1_req_wmask : m0_req_wmask;
        m0_req_ready = (gnt_q == MST_IFU) && s_req_ready;
        m1_req_ready = (gnt_q == MST_LSU) && s_req_ready;
        if (s_req_valid && s_req_ready) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        m0_resp_valid = (gnt_q == MST_IFU) && s_resp_valid;
        m1_resp_valid = (gnt_q == MST_LSU) && s_resp_valid;
        m0_resp_rdata = (gnt_q == MST_IFU) ? s_resp_rdata : '0;
        m1_resp_rdata = (gnt_q == MST_LSU) ? s_resp_rdata : '0;
        s_resp_ready  = (gnt_q == MST_LSU) ? m1_resp_ready : m0_resp_ready;
        if (s_resp_valid && s_resp_ready) begin
          last_next  = gnt_q;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign gnt  = gnt_q;
  assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Directed bench for the memory arbiter; the bench plays both masters and the slave.
module tb_ysyx_24070014_mem_arbiter;

  logic        clock, reset_n;
  logic        m0_req_valid, m0_req_ready, m0_req_wen, m0_resp_valid, m0_resp_ready;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_resp_rdata;
  logic [3:0]  m0_req_wmask;
  logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_resp_valid, m1_resp_ready;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_rdata;
  logic [3:0]  m1_req_wmask;
  logic        s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready;
  logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
  logic [3:0]  s_req_wmask;
  logic        gnt, busy;

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  ysyx_24070014_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata), .s_resp_ready(s_resp_ready),
    .gnt(gnt), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic m, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] wmask);
    exp_t e;
    e.m = m; e.addr = addr; e.wen = wen; e.wdata = wdata; e.wmask = wmask;
    sb.push_back(e);
  endtask

  task automatic raise(input logic m, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] wmask);
    if (m) begin
      m1_req_addr = addr; m1_req_wen = wen; m1_req_wdata = wdata; m1_req_wmask = wmask;
      m1_req_valid = 1'b1;
    end else begin
      m0_req_addr = addr; m0_req_wen = wen; m0_req_wdata = wdata; m0_req_wmask = wmask;
      m0_req_valid = 1'b1;
    end
    push_exp(m, addr, wen, wdata, wmask);
  endtask

  // One slave-side transaction: request accepted after req_wait cycles, response
  // accepted by the master after resp_wait cycles. keep leaves the master's request up.
  task automatic serve(input int req_wait, input int resp_wait, input logic [31:0] rdata,
                       input logic keep);
    exp_t e;
    int   guard;
    guard = 0;
    while (!s_req_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("req_arrival", {31'd0, s_req_valid}, 32'd1);
    if (!s_req_valid) return;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < req_wait; i++) begin
      check("bp_req_gnt",   {31'd0, gnt}, {31'd0, e.m});
      check("bp_req_addr",  s_req_addr, e.addr);
      check("bp_req_valid", {31'd0, s_req_valid}, 32'd1);
      check("bp_req_rdy",   {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
      tick();
    end
    check("req_gnt",   {31'd0, gnt}, {31'd0, e.m});
    check("req_busy",  {31'd0, busy}, 32'd1);
    check("req_addr",  s_req_addr, e.addr);
    check("req_wen",   {31'd0, s_req_wen}, {31'd0, e.wen});
    check("req_wdata", s_req_wdata, e.wdata);
    check("req_wmask", {28'd0, s_req_wmask}, {28'd0, e.wmask});
    s_req_ready = 1'b1;
    #1;
    check("req_ready_routing", {30'd0, m1_req_ready, m0_req_ready}, e.m ? 32'd2 : 32'd1);
    tick();
    s_req_ready = 1'b0;
    if (!keep) begin
      if (e.m) m1_req_valid = 1'b0;
      else     m0_req_valid = 1'b0;
    end
    check("resp_state_busy", {31'd0, busy}, 32'd1);
    check("resp_state_sreq", {31'd0, s_req_valid}, 32'd0);
    s_resp_valid = 1'b1;
    s_resp_rdata = rdata;
    #1;
    check("resp_valid_routing", {30'd0, m1_resp_valid, m0_resp_valid}, e.m ? 32'd2 : 32'd1);
    check("resp_rdata",  e.m ? m1_resp_rdata : m0_resp_rdata, rdata);
    check("resp_other_rdata", e.m ? m0_resp_rdata : m1_resp_rdata, 32'd0);
    for (int i = 0; i < resp_wait; i++) begin
      tick();
      check("bp_resp_gnt",   {31'd0, gnt}, {31'd0, e.m});
      check("bp_resp_busy",  {31'd0, busy}, 32'd1);
      check("bp_resp_ready", {31'd0, s_resp_ready}, 32'd0);
    end
    if (e.m) m1_resp_ready = 1'b1;
    else     m0_resp_ready = 1'b1;
    #1;
    check("s_resp_ready", {31'd0, s_resp_ready}, 32'd1);
    tick();
    s_resp_valid  = 1'b0;
    m0_resp_ready = 1'b0;
    m1_resp_ready = 1'b0;
    check("idle_after_txn", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic g_hold;
    reset_n = 1'b0;
    m0_req_valid = 0; m0_req_addr = 0; m0_req_wen = 0; m0_req_wdata = 0; m0_req_wmask = 0;
    m1_req_valid = 0; m1_req_addr = 0; m1_req_wen = 0; m1_req_wdata = 0; m1_req_wmask = 0;
    m0_resp_ready = 0; m1_resp_ready = 0;
    s_req_ready = 0; s_resp_valid = 0; s_resp_rdata = 0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt",  {31'd0, gnt}, 32'd0);
    check("rst_valids_readies", {25'd0, s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready,
          m0_resp_valid, m1_resp_valid, s_req_wen}, 32'd0);
    check("rst_req_addr", s_req_addr, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    // single IFU read, visible at the slave one cycle after valid
    raise(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'hF);
    check("ifu_not_yet_visible", {31'd0, s_req_valid}, 32'd0);
    tick();
    check("ifu_visible_next", {31'd0, s_req_valid}, 32'd1);
    serve(0, 0, 32'h0000_0413, 1'b0);

    // simultaneous requests from a fresh reset alternate 0,1,0,1
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    raise(1'b0, 32'h8000_0100, 1'b0, 32'd0, 4'hF);
    raise(1'b1, 32'h8000_0200, 1'b0, 32'd0, 4'hF);
    push_exp(1'b0, 32'h8000_0100, 1'b0, 32'd0, 4'hF);
    push_exp(1'b1, 32'h8000_0200, 1'b0, 32'd0, 4'hF);
    serve(0, 0, 32'h1111_0000, 1'b1);
    serve(0, 0, 32'h2222_0000, 1'b1);
    serve(1, 0, 32'h3333_0000, 1'b0);
    serve(0, 1, 32'h4444_0000, 1'b0);

    // LSU write while IFU waits
    raise(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    tick();
    raise(1'b0, 32'h8000_0004, 1'b0, 32'd0, 4'hF);
    serve(0, 0, 32'h0000_0000, 1'b0);
    serve(0, 0, 32'h0000_0513, 1'b0);

    // back-pressure on both request and response
    raise(1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'hF);
    serve(5, 3, 32'hCAFE_F00D, 1'b0);

    // reset while in RESP
    m1_req_addr = 32'h8000_3000; m1_req_wen = 0; m1_req_wdata = 0; m1_req_wmask = 4'hF;
    m1_req_valid = 1'b1;
    tick();
    check("mid_gnt_lsu", {31'd0, gnt}, 32'd1);
    s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0;
    s_resp_valid = 1'b1;
    s_resp_rdata = 32'h5555_AAAA;
    #1;
    check("mid_resp_valid", {31'd0, m1_resp_valid}, 32'd1);
    raise(1'b0, 32'h8000_0008, 1'b0, 32'd0, 4'hF);
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_gnt",  {31'd0, gnt}, 32'd0);
    check("arst_outs", {26'd0, s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready,
          m0_resp_valid, m1_resp_valid}, 32'd0);
    tick();
    s_resp_valid = 1'b0;
    reset_n = 1'b1;
    push_exp(1'b1, 32'h8000_3000, 1'b0, 32'd0, 4'hF);
    serve(0, 0, 32'h0000_0613, 1'b0);
    serve(0, 0, 32'h7777_7777, 1'b0);

    // idle
    g_hold = gnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_sreq", {31'd0, s_req_valid}, 32'd0);
      check("idle_gnt",  {31'd0, gnt}, {31'd0, g_hold});
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
